// File: rtl/oops_structs.sv
// Shared types for the OOPs RV32I core: ALU opcodes, reservation-station
// entries and common-data-bus lanes.
package oops_structs;

  localparam int ROB_IDX_LEN = 4;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_BEQ   = 5'd10,
    ALU_BNE   = 5'd11,
    ALU_BLT   = 5'd12,
    ALU_BGE   = 5'd13,
    ALU_BLTU  = 5'd14,
    ALU_BGEU  = 5'd15,
    ALU_PASS2 = 5'd16
  } alu_op_t;

  typedef struct packed {
    logic                   CB1;
    logic                   CB2;
    logic [31:0]            val1;
    logic [31:0]            val2;
    alu_op_t                op;
    logic [ROB_IDX_LEN-1:0] rob_dest;
  } reservation_station_element_t;

  typedef struct packed {
    logic                   valid;
    logic [ROB_IDX_LEN-1:0] ROB_dest;
    logic [31:0]            data;
  } cdb_lane_t;

endpackage

// File: rtl/alu_execution_unit_if.sv
// Reservation-station issue port plus one CDB lane, as seen by an execution unit.
interface alu_execution_unit_if #(
  parameter int ROB_IDX_LEN = 4
);
  logic                   vld_i;
  logic                   rdy_i;
  logic [4:0]             op_i;
  logic [31:0]            val1_i;
  logic [31:0]            val2_i;
  logic                   cb1_i;
  logic                   cb2_i;
  logic [ROB_IDX_LEN-1:0] rob_dest_i;
  logic                   cdb_valid_o;
  logic [ROB_IDX_LEN-1:0] cdb_rob_dest_o;
  logic [31:0]            cdb_data_o;

  // master = reservation station / CDB consumer side, slave = execution unit
  modport master (
    output vld_i, op_i, val1_i, val2_i, cb1_i, cb2_i, rob_dest_i,
    input  rdy_i, cdb_valid_o, cdb_rob_dest_o, cdb_data_o
  );

  modport slave (
    input  vld_i, op_i, val1_i, val2_i, cb1_i, cb2_i, rob_dest_i,
    output rdy_i, cdb_valid_o, cdb_rob_dest_o, cdb_data_o
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational RV32I ALU / branch comparator. Compare ops return 0 or 1,
// undefined opcodes return 0.
module alu_core (
  input  logic [4:0]  op,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  output logic [31:0] result
);
  import oops_structs::*;

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = val2[4:0];
  assign lt_signed   = $signed(val1) < $signed(val2);
  assign lt_unsigned = val1 < val2;

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:   result = val1 + val2;
      ALU_SUB:   result = val1 - val2;
      ALU_SLL:   result = val1 << shamt;
      ALU_SLT:   result = {31'd0, lt_signed};
      ALU_SLTU:  result = {31'd0, lt_unsigned};
      ALU_XOR:   result = val1 ^ val2;
      ALU_SRL:   result = val1 >> shamt;
      ALU_SRA:   result = 32'($signed(val1) >>> shamt);
      ALU_OR:    result = val1 | val2;
      ALU_AND:   result = val1 & val2;
      ALU_BEQ:   result = {31'd0, val1 == val2};
      ALU_BNE:   result = {31'd0, val1 != val2};
      ALU_BLT:   result = {31'd0, lt_signed};
      ALU_BGE:   result = {31'd0, ~lt_signed};
      ALU_BLTU:  result = {31'd0, lt_unsigned};
      ALU_BGEU:  result = {31'd0, ~lt_unsigned};
      ALU_PASS2: result = val2;
      default:   result = 32'd0;
    endcase
  end
endmodule

// File: rtl/alu_execution_unit.sv
// Single-lane integer execution unit: optional input register, ALU, optional
// output register, driving one CDB lane. Never back-pressures.
module alu_execution_unit #(
  parameter bit REG_IN      = 1'b0,
  parameter bit REG_OUT     = 1'b0,
  parameter int ROB_IDX_LEN = oops_structs::ROB_IDX_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fls_i,
  alu_execution_unit_if.slave eu
);
  import oops_structs::*;

  typedef struct packed {
    logic                   vld;
    logic [4:0]             op;
    logic [31:0]            val1;
    logic [31:0]            val2;
    logic [ROB_IDX_LEN-1:0] tag;
  } op_stage_t;

  typedef struct packed {
    logic                   vld;
    logic [ROB_IDX_LEN-1:0] tag;
    logic [31:0]            data;
  } res_stage_t;

  logic       accept;
  op_stage_t  issue_op;
  op_stage_t  s1_op;
  logic       s1_live;
  logic [31:0] alu_result;
  res_stage_t s1_res;
  res_stage_t out_res;

  assign eu.rdy_i = rst;
  assign accept   = eu.vld_i & rst & ~fls_i;

  assign issue_op = '{vld: accept, op: eu.op_i, val1: eu.val1_i,
                      val2: eu.val2_i, tag: eu.rob_dest_i};

  generate
    if (REG_IN) begin : g_reg_in
      op_stage_t in_stage_reg;

      always_ff @(posedge clk) begin
        if (!rst)
          in_stage_reg <= '0;
        else if (accept)
          in_stage_reg <= issue_op;
        else
          in_stage_reg.vld <= 1'b0;
      end

      assign s1_op = in_stage_reg;
    end else begin : g_comb_in
      assign s1_op = issue_op;
    end
  endgenerate

  alu_core u_alu_core (
    .op     (s1_op.op),
    .val1   (s1_op.val1),
    .val2   (s1_op.val2),
    .result (alu_result)
  );

  // A flush also kills an op sitting in the input register before it reaches the lane.
  assign s1_live = s1_op.vld & ~fls_i & rst;
  assign s1_res  = '{vld: s1_live, tag: s1_op.tag, data: alu_result};

  generate
    if (REG_OUT) begin : g_reg_out
      res_stage_t out_stage_reg;

      always_ff @(posedge clk) begin
        if (!rst)
          out_stage_reg <= '0;
        else if (s1_live)
          out_stage_reg <= s1_res;
        else
          out_stage_reg.vld <= 1'b0;
      end

      assign out_res = out_stage_reg;
    end else begin : g_comb_out
      assign out_res = s1_res;
    end
  endgenerate

  // Outputs are forced to zero while reset is held, even in the combinational build.
  assign eu.cdb_valid_o    = rst & out_res.vld;
  assign eu.cdb_rob_dest_o = rst ? out_res.tag  : '0;
  assign eu.cdb_data_o     = rst ? out_res.data : 32'd0;

  cb_clear_on_accept: assert property (
    @(posedge clk) disable iff (!rst) accept |-> !(eu.cb1_i | eu.cb2_i)
  );
endmodule

// File: tb/tb_alu_execution_unit.sv
// Directed bench: three unit builds (comb, REG_OUT only, REG_IN+REG_OUT) fed the
// same op stream; each lane is checked at its own latency.
module tb_alu_execution_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fls = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_execution_unit_if #(.ROB_IDX_LEN(4)) if00 ();
  alu_execution_unit_if #(.ROB_IDX_LEN(4)) if01 ();
  alu_execution_unit_if #(.ROB_IDX_LEN(4)) if11 ();

  alu_execution_unit #(.REG_IN(1'b0), .REG_OUT(1'b0), .ROB_IDX_LEN(4)) u00 (
    .clk(clk), .rst(rst), .fls_i(fls), .eu(if00));
  alu_execution_unit #(.REG_IN(1'b0), .REG_OUT(1'b1), .ROB_IDX_LEN(4)) u01 (
    .clk(clk), .rst(rst), .fls_i(fls), .eu(if01));
  alu_execution_unit #(.REG_IN(1'b1), .REG_OUT(1'b1), .ROB_IDX_LEN(4)) u11 (
    .clk(clk), .rst(rst), .fls_i(fls), .eu(if11));

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    if00.vld_i = v; if00.op_i = op; if00.val1_i = a; if00.val2_i = b; if00.rob_dest_i = tag;
    if01.vld_i = v; if01.op_i = op; if01.val1_i = a; if01.val2_i = b; if01.rob_dest_i = tag;
    if11.vld_i = v; if11.op_i = op; if11.val1_i = a; if11.val2_i = b; if11.rob_dest_i = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs = '{
      '{5'd0,  32'h7FFFFFFF, 32'h00000001, 4'd3,  32'h80000000},  // ADD overflow
      '{5'd7,  32'h80000000, 32'h0000001F, 4'd5,  32'hFFFFFFFF},  // SRA
      '{5'd6,  32'h80000000, 32'h0000001F, 4'd6,  32'h00000001},  // SRL
      '{5'd12, 32'hFFFFFFFF, 32'h00000001, 4'd7,  32'h00000001},  // BLT
      '{5'd14, 32'hFFFFFFFF, 32'h00000001, 4'd8,  32'h00000000},  // BLTU
      '{5'd13, 32'h00000005, 32'h00000005, 4'd9,  32'h00000001},  // BGE
      '{5'd4,  32'h00000000, 32'h00000001, 4'd10, 32'h00000001},  // SLTU
      '{5'd11, 32'h00000007, 32'h00000007, 4'd11, 32'h00000000},  // BNE
      '{5'd1,  32'h00000003, 32'h00000005, 4'd12, 32'hFFFFFFFE},  // SUB
      '{5'd2,  32'h00000001, 32'h00000023, 4'd13, 32'h00000008},  // SLL uses val2[4:0]
      '{5'd5,  32'h0000F0F0, 32'h0000FF00, 4'd14, 32'h00000FF0},  // XOR
      '{5'd8,  32'h000000F0, 32'h0000000F, 4'd15, 32'h000000FF},  // OR
      '{5'd9,  32'h000000F0, 32'h0000003C, 4'd0,  32'h00000030},  // AND
      '{5'd3,  32'hFFFFFFFF, 32'h00000000, 4'd1,  32'h00000001},  // SLT
      '{5'd16, 32'h00001234, 32'h0000ABCD, 4'd2,  32'h0000ABCD},  // PASS2
      '{5'd20, 32'h00000005, 32'h00000005, 4'd4,  32'h00000000},  // undefined
      '{5'd15, 32'h00000001, 32'hFFFFFFFF, 4'd6,  32'h00000000},  // BGEU
      '{5'd10, 32'h00000009, 32'h00000009, 4'd7,  32'h00000001}   // BEQ
    };

    if00.cb1_i = 1'b0; if00.cb2_i = 1'b0;
    if01.cb1_i = 1'b0; if01.cb2_i = 1'b0;
    if11.cb1_i = 1'b0; if11.cb2_i = 1'b0;

    // Reset with a valid op presented: nothing may leak out, even combinationally.
    drive(1'b1, 5'd0, 32'd2, 32'd3, 4'd9);
    tick(); tick();
    #2;
    chk("rst_rdy00", {31'd0, if00.rdy_i}, 32'd0);
    chk("rst_rdy11", {31'd0, if11.rdy_i}, 32'd0);
    chk("rst_vld00", {31'd0, if00.cdb_valid_o}, 32'd0);
    chk("rst_data00", if00.cdb_data_o, 32'd0);
    chk("rst_tag00", {28'd0, if00.cdb_rob_dest_o}, 32'd0);
    chk("rst_vld11", {31'd0, if11.cdb_valid_o}, 32'd0);
    chk("rst_data11", if11.cdb_data_o, 32'd0);
    $display("txn reset hold checked");

    drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
    tick();
    rst = 1'b1;
    #2;
    chk("rdy00", {31'd0, if00.rdy_i}, 32'd1);

    // Directed vector stream, back-to-back; each build checked at its latency.
    for (int c = 0; c < NV + 3; c++) begin
      tick();
      if (c < NV) drive(1'b1, vecs[c].op, vecs[c].a, vecs[c].b, vecs[c].tag);
      else        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
      #2;
      if (c < NV) begin
        chk($sformatf("v%0d_vld00", c), {31'd0, if00.cdb_valid_o}, 32'd1);
        chk($sformatf("v%0d_data00", c), if00.cdb_data_o, vecs[c].exp);
        chk($sformatf("v%0d_tag00", c), {28'd0, if00.cdb_rob_dest_o}, {28'd0, vecs[c].tag});
        $display("txn op=%0d a=%h b=%h tag=%0d -> data=%h", vecs[c].op, vecs[c].a,
                 vecs[c].b, vecs[c].tag, if00.cdb_data_o);
      end else begin
        chk($sformatf("c%0d_idle00", c), {31'd0, if00.cdb_valid_o}, 32'd0);
      end
      if (c >= 1 && c <= NV) begin
        chk($sformatf("v%0d_vld01", c-1), {31'd0, if01.cdb_valid_o}, 32'd1);
        chk($sformatf("v%0d_data01", c-1), if01.cdb_data_o, vecs[c-1].exp);
        chk($sformatf("v%0d_tag01", c-1), {28'd0, if01.cdb_rob_dest_o}, {28'd0, vecs[c-1].tag});
      end else begin
        chk($sformatf("c%0d_idle01", c), {31'd0, if01.cdb_valid_o}, 32'd0);
      end
      if (c >= 2 && c <= NV + 1) begin
        chk($sformatf("v%0d_vld11", c-2), {31'd0, if11.cdb_valid_o}, 32'd1);
        chk($sformatf("v%0d_data11", c-2), if11.cdb_data_o, vecs[c-2].exp);
        chk($sformatf("v%0d_tag11", c-2), {28'd0, if11.cdb_rob_dest_o}, {28'd0, vecs[c-2].tag});
      end else begin
        chk($sformatf("c%0d_idle11", c), {31'd0, if11.cdb_valid_o}, 32'd0);
      end
    end

    // Flush: SUB accepted, flush next cycle while another op is offered.
    tick();
    drive(1'b1, 5'd1, 32'd10, 32'd3, 4'd9);
    tick();
    drive(1'b1, 5'd0, 32'd1, 32'd1, 4'd2);
    fls = 1'b1;
    #2;
    chk("fls_vld00", {31'd0, if00.cdb_valid_o}, 32'd0);
    chk("fls_vld11", {31'd0, if11.cdb_valid_o}, 32'd0);
    tick();
    fls = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
    #2;
    chk("fls_after1_vld11", {31'd0, if11.cdb_valid_o}, 32'd0);
    chk("fls_after1_vld01", {31'd0, if01.cdb_valid_o}, 32'd0);
    tick();
    #2;
    chk("fls_after2_vld11", {31'd0, if11.cdb_valid_o}, 32'd0);
    $display("txn flush SUB tag=9 discarded");

    // Op after the flush completes normally.
    drive(1'b1, 5'd1, 32'd10, 32'd3, 4'd4);
    #2;
    chk("postfls_data00", if00.cdb_data_o, 32'd7);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
    tick();
    #2;
    chk("postfls_vld11", {31'd0, if11.cdb_valid_o}, 32'd1);
    chk("postfls_data11", if11.cdb_data_o, 32'd7);
    chk("postfls_tag11", {28'd0, if11.cdb_rob_dest_o}, 32'd4);
    $display("txn SUB 10-3 tag=4 -> data=%h", if11.cdb_data_o);
    tick();
    #2;
    chk("postfls_drop11", {31'd0, if11.cdb_valid_o}, 32'd0);

    // Reset while an op sits in the REG_IN stage.
    drive(1'b1, 5'd0, 32'd2, 32'd3, 4'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
    rst = 1'b0;
    #2;
    chk("midrst_rdy11", {31'd0, if11.rdy_i}, 32'd0);
    chk("midrst_vld11", {31'd0, if11.cdb_valid_o}, 32'd0);
    chk("midrst_data11", if11.cdb_data_o, 32'd0);
    chk("midrst_vld01", {31'd0, if01.cdb_valid_o}, 32'd0);
    chk("midrst_data01", if01.cdb_data_o, 32'd0);
    tick();
    rst = 1'b1;
    #2;
    chk("postrst1_vld11", {31'd0, if11.cdb_valid_o}, 32'd0);
    tick();
    #2;
    chk("postrst2_vld11", {31'd0, if11.cdb_valid_o}, 32'd0);
    $display("txn reset discarded ADD tag=1");

    drive(1'b1, 5'd5, 32'h000000FF, 32'h0000000F, 4'd2);
    #2;
    chk("postrst_data00", if00.cdb_data_o, 32'h000000F0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
    tick();
    #2;
    chk("postrst_vld11", {31'd0, if11.cdb_valid_o}, 32'd1);
    chk("postrst_data11", if11.cdb_data_o, 32'h000000F0);
    chk("postrst_tag11", {28'd0, if11.cdb_rob_dest_o}, 32'd2);
    $display("txn XOR ff^0f tag=2 -> data=%h", if11.cdb_data_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
